// File: rtl/mem_lane_gather_pkg.sv
// Shared package for the memory lane gather block: derived widths,
// the lane/slot to PE mapping and the end-of-loop FSM state type.
package mem_gather_pkg;

  typedef enum logic {
    EOL_WAIT  = 1'b0,   // watching for the PU set to complete
    EOL_FIRED = 1'b1    // eol already issued, waiting for eoc
  } eol_state_e;

  // Ceiling log2; clog2_f(1) == 0.
  function automatic int clog2_f(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Number of PE slots that share one memory lane.
  function automatic int per_lane_f(input int num_pu, input int num_pe,
                                    input int num_lanes);
    return (num_pu * num_pe) / num_lanes;
  endfunction

  // Slot select width, never narrower than one bit.
  function automatic int sel_w_f(input int per_lane);
    return (per_lane <= 1) ? 1 : clog2_f(per_lane);
  endfunction

  // Lane i, slot j reads PE i + j*NUM_LANES.
  function automatic int slot_to_pe(input int lane, input int slot,
                                    input int num_lanes);
    return lane + slot * num_lanes;
  endfunction

endpackage

// File: rtl/mem_lane_gather_if.sv
// Bus bundle for mem_lane_gather: read request, PE data, loop control
// and the gathered result.
//
// Handshake: there is no ready. rd_v is a one-cycle request strobe that
// the block accepts on every cycle it is high; out_v is a one-cycle
// qualifier on out_data with no backpressure, and out_data holds while
// out_v is low. pu_done and eoc are single-cycle pulses, eol is a
// single-cycle pulse back to the sequencer.
interface mem_lane_gather_if
  import mem_gather_pkg::*;
#(
  parameter int NUM_PU    = 8,
  parameter int NUM_PE    = 8,
  parameter int NUM_LANES = 16,
  parameter int DATA_LEN  = 16
);
  localparam int PER_LANE = per_lane_f(NUM_PU, NUM_PE, NUM_LANES);
  localparam int SEL_W    = sel_w_f(PER_LANE);

  logic                              rd_v;
  logic [NUM_LANES*SEL_W-1:0]        rd_sel;
  logic [NUM_PU*NUM_PE*DATA_LEN-1:0] pe_data;
  logic [NUM_PU-1:0]                 pu_en;
  logic [NUM_PU-1:0]                 pu_done;
  logic                              eoc;
  logic [NUM_LANES*DATA_LEN-1:0]     out_data;
  logic                              out_v;
  logic                              busy;
  logic                              eol;
  eol_state_e                        eol_state;

  modport master (
    output rd_v, rd_sel, pe_data, pu_en, pu_done, eoc,
    input  out_data, out_v, busy, eol, eol_state
  );

  modport slave (
    input  rd_v, rd_sel, pe_data, pu_en, pu_done, eoc,
    output out_data, out_v, busy, eol, eol_state
  );

endinterface

// File: rtl/mem_lane_gather_mux.sv
// One lane's slot selector: picks one of NUM_DATA words, zero when the
// select is past the last slot.
module gather_lane_mux
  import mem_gather_pkg::*;
#(
  parameter int  DATA_WIDTH = 16,
  parameter int  NUM_DATA   = 4,
  localparam int SEL_W      = sel_w_f(NUM_DATA)
) (
  input  logic [SEL_W-1:0]               sel_i,
  input  logic [NUM_DATA*DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0]          data_o
);

  // Compare-and-pick so out-of-range selects fall through to zero.
  always_comb begin
    data_o = '0;
    for (int j = 0; j < NUM_DATA; j++) begin
      if (sel_i == SEL_W'(j)) begin
        data_o = data_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/mem_lane_gather.sv
// Gathers PE read data onto memory lanes LAT+1 cycles after a read
// request, tracks reads in flight, and raises a one-cycle end-of-loop
// pulse once every enabled PU has reported done.
module mem_lane_gather
  import mem_gather_pkg::*;
#(
  parameter int NUM_PU    = 8,
  parameter int NUM_PE    = 8,
  parameter int NUM_LANES = 16,
  parameter int DATA_LEN  = 16,
  parameter int LAT       = 3
) (
  input logic               clk,
  input logic               reset,
  mem_lane_gather_if.slave  bus
);

  localparam int PER_LANE = per_lane_f(NUM_PU, NUM_PE, NUM_LANES);
  localparam int SEL_W    = sel_w_f(PER_LANE);
  localparam int SELS_W   = NUM_LANES * SEL_W;
  localparam int CNT_W    = clog2_f(LAT + 2);

  logic [LAT-1:0]                dl_v_q;
  logic [SELS_W-1:0]             dl_sel_q [LAT];
  logic [NUM_LANES*DATA_LEN-1:0] gathered;
  logic [NUM_LANES*DATA_LEN-1:0] out_data_q;
  logic                          out_v_q;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [NUM_PU-1:0]             done_flag_q, done_flag_d;
  logic                          all_done_d;
  logic                          eol_q;
  eol_state_e                    eol_state_q;

  // Delay line carrying each request's select and valid bit for LAT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      dl_v_q <= '0;
      for (int k = 0; k < LAT; k++) dl_sel_q[k] <= '0;
    end else begin
      dl_v_q[0]   <= bus.rd_v;
      dl_sel_q[0] <= bus.rd_sel;
      for (int k = 1; k < LAT; k++) begin
        dl_v_q[k]   <= dl_v_q[k-1];
        dl_sel_q[k] <= dl_sel_q[k-1];
      end
    end
  end

  // Per-lane slot muxes, driven by the select that has aged LAT cycles.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [PER_LANE*DATA_LEN-1:0] lane_data;
    logic [SEL_W-1:0]             lane_sel;

    for (genvar j = 0; j < PER_LANE; j++) begin : g_slot
      assign lane_data[j*DATA_LEN +: DATA_LEN] =
        bus.pe_data[slot_to_pe(i, j, NUM_LANES)*DATA_LEN +: DATA_LEN];
    end

    // With a single slot per lane the select carries no information.
    assign lane_sel = (PER_LANE == 1) ? '0 : dl_sel_q[LAT-1][i*SEL_W +: SEL_W];

    gather_lane_mux #(
      .DATA_WIDTH (DATA_LEN),
      .NUM_DATA   (PER_LANE)
    ) u_mux (
      .sel_i  (lane_sel),
      .data_i (lane_data),
      .data_o (gathered[i*DATA_LEN +: DATA_LEN])
    );
  end

  // Output register; data only updates with a valid so it holds otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q <= '0;
      out_v_q    <= 1'b0;
    end else begin
      out_v_q <= dl_v_q[LAT-1];
      if (dl_v_q[LAT-1]) out_data_q <= gathered;
    end
  end

  // In-flight count: +1 per request, -1 per delivered word.
  always_comb begin
    cnt_d = cnt_q;
    case ({bus.rd_v, out_v_q})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // In-flight counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Next done flags (eoc beats a same-cycle pu_done) and a look-ahead
  // all_done so eol lands on the cycle after the completing pu_done.
  always_comb begin
    done_flag_d = bus.eoc ? '0 : (done_flag_q | bus.pu_done);
    all_done_d  = (bus.pu_en != '0) && (&(done_flag_d | ~bus.pu_en));
  end

  // End-of-loop FSM: fire once per loop, re-arm only on eoc.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_flag_q <= '0;
      eol_q       <= 1'b0;
      eol_state_q <= EOL_WAIT;
    end else begin
      done_flag_q <= done_flag_d;
      eol_q       <= 1'b0;
      case (eol_state_q)
        EOL_WAIT: begin
          if (all_done_d) begin
            eol_q       <= 1'b1;
            eol_state_q <= EOL_FIRED;
          end
        end
        EOL_FIRED: begin
          if (bus.eoc) eol_state_q <= EOL_WAIT;
        end
      endcase
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_v     = out_v_q;
  assign bus.busy      = (cnt_q != '0);
  assign bus.eol       = eol_q;
  assign bus.eol_state = eol_state_q;

endmodule

// File: tb/tb_mem_lane_gather.sv
// Bench for mem_lane_gather: a PER_LANE=4 instance with a running
// reference model, and a PER_LANE=3 instance for out-of-range selects.
module tb_mem_lane_gather;
  import mem_gather_pkg::*;

  localparam int LAT = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_lane_gather_if #(.NUM_PU(2), .NUM_PE(8), .NUM_LANES(4), .DATA_LEN(16)) bus1 ();
  mem_lane_gather_if #(.NUM_PU(2), .NUM_PE(6), .NUM_LANES(4), .DATA_LEN(16)) bus2 ();

  mem_lane_gather #(.NUM_PU(2), .NUM_PE(8), .NUM_LANES(4), .DATA_LEN(16), .LAT(LAT)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  mem_lane_gather #(.NUM_PU(2), .NUM_PE(6), .NUM_LANES(4), .DATA_LEN(16), .LAT(LAT)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  // ---------------- helpers / driver tasks ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus1.rd_v    = 1'b0;
    bus1.rd_sel  = '0;
    bus1.pu_done = '0;
    bus1.eoc     = 1'b0;
    bus2.rd_v    = 1'b0;
    bus2.rd_sel  = '0;
  endtask

  task automatic set_pe_fixed();
    for (int k = 0; k < 16; k++) bus1.pe_data[k*16 +: 16] = 16'h100 + 16'(k);
    for (int k = 0; k < 12; k++) bus2.pe_data[k*16 +: 16] = 16'h200 + 16'(k);
  endtask

  // Lane i with slot s reads PE i + 4*s; slots past per_lane read zero.
  function automatic logic [63:0] gather(input logic [7:0] sel, input logic [255:0] pe,
                                         input int per_lane);
    logic [63:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = int'(sel[i*2 +: 2]);
      if (s < per_lane) r[i*16 +: 16] = pe[(i + s*4)*16 +: 16];
    end
    return r;
  endfunction

  // ---------------- scoreboard / reference model for dut1 ----------------
  typedef struct {
    int          due;
    logic [7:0]  sel;
  } pend_t;

  pend_t       pend_q[$];
  logic [63:0] exp_q[$];
  logic [63:0] last_data;
  logic [63:0] m_ed;
  logic        e_busy, e_eol, m_popped, m_all, m_fired;
  logic [1:0]  m_flags;
  bit          mdl_ok = 1'b0;

  always @(negedge clk) begin
    if (mdl_ok) begin
      if (exp_q.size() != 0) begin
        m_ed = exp_q.pop_front();
        chk("mon_out_v", 64'(bus1.out_v), 64'(1'b1));
        chk("mon_out_data", bus1.out_data, m_ed);
        last_data = m_ed;
      end else begin
        chk("mon_out_v", 64'(bus1.out_v), 64'(1'b0));
        chk("mon_hold", bus1.out_data, last_data);
      end
      chk("mon_busy", 64'(bus1.busy), 64'(e_busy));
      chk("mon_eol", 64'(bus1.eol), 64'(e_eol));
    end
    if (reset) begin
      pend_q.delete();
      exp_q.delete();
      last_data = '0;
      e_busy    = 1'b0;
      e_eol     = 1'b0;
      m_flags   = '0;
      m_fired   = 1'b0;
    end else begin
      m_popped = 1'b0;
      if (pend_q.size() != 0 && pend_q[0].due == cyc) begin
        exp_q.push_back(gather(pend_q[0].sel, bus1.pe_data, 4));
        void'(pend_q.pop_front());
        m_popped = 1'b1;
      end
      if (bus1.rd_v) pend_q.push_back('{due: cyc + LAT, sel: bus1.rd_sel});
      e_busy  = (pend_q.size() != 0) || m_popped;
      m_flags = bus1.eoc ? 2'b00 : (m_flags | bus1.pu_done);
      m_all   = (bus1.pu_en != 2'b00) && ((m_flags | ~bus1.pu_en) == 2'b11);
      e_eol   = m_all && !m_fired;
      if (bus1.eoc) m_fired = 1'b0;
      else if (e_eol) m_fired = 1'b1;
    end
    mdl_ok = 1'b1;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0]  sel1;
    logic [63:0] exp1;
    logic [7:0]  sel2;
    logic [63:0] exp2;
  } rd_vec_t;

  rd_vec_t tv [5];

  // ---------------- test sequence ----------------
  initial begin
    tv[0] = '{8'hE4, 64'h010F_010A_0105_0100, 8'hE4, 64'h0000_020A_0205_0200};
    tv[1] = '{8'h00, 64'h0103_0102_0101_0100, 8'h39, 64'h0203_0000_0209_0204};
    tv[2] = '{8'hFF, 64'h010F_010E_010D_010C, 8'hFF, 64'h0000_0000_0000_0000};
    tv[3] = '{8'h1B, 64'h0103_0106_0109_010C, 8'hA0, 64'h020B_020A_0201_0200};
    tv[4] = '{8'h55, 64'h0107_0106_0105_0104, 8'h00, 64'h0203_0202_0201_0200};

    reset = 1'b1;
    idle();
    bus1.pu_en   = 2'b00;
    bus2.pu_en   = 2'b00;
    bus2.pu_done = 2'b00;
    bus2.eoc     = 1'b0;
    set_pe_fixed();
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // reset state
    chk("rst_out_v1", 64'(bus1.out_v), 64'(1'b0));
    chk("rst_out_data1", bus1.out_data, 64'h0);
    chk("rst_busy1", 64'(bus1.busy), 64'(1'b0));
    chk("rst_eol1", 64'(bus1.eol), 64'(1'b0));
    chk("rst_out_v2", 64'(bus2.out_v), 64'(1'b0));
    chk("rst_out_data2", bus2.out_data, 64'h0);
    chk("rst_busy2", 64'(bus2.busy), 64'(1'b0));

    // single reads from the table, both instances in parallel
    for (int e = 0; e < 5; e++) begin
      bus1.rd_v = 1'b1; bus1.rd_sel = tv[e].sel1;
      bus2.rd_v = 1'b1; bus2.rd_sel = tv[e].sel2;
      tick();
      idle();
      chk("tbl_busy_t1", 64'(bus1.busy), 64'(1'b1));
      tick(); tick();
      chk("tbl_out_v_t3", 64'(bus1.out_v), 64'(1'b0));
      tick();
      chk("tbl_out_v1", 64'(bus1.out_v), 64'(1'b1));
      chk("tbl_data1", bus1.out_data, tv[e].exp1);
      chk("tbl_out_v2", 64'(bus2.out_v), 64'(1'b1));
      chk("tbl_data2", bus2.out_data, tv[e].exp2);
      chk("tbl_busy_t4", 64'(bus1.busy), 64'(1'b1));
      tick();
      chk("tbl_out_v_t5", 64'(bus1.out_v), 64'(1'b0));
      chk("tbl_hold", bus1.out_data, tv[e].exp1);
      chk("tbl_busy_t5", 64'(bus1.busy), 64'(1'b0));
    end

    // eight back-to-back reads with rotating selects
    bus1.rd_v = 1'b1;
    bus1.rd_sel = 8'hE4;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("b2b_out_v", 64'(bus1.out_v), 64'(k >= 4 && k <= 11));
      chk("b2b_busy", 64'(bus1.busy), 64'(k <= 11));
      idle();
      if (k < 8) begin
        bus1.rd_v   = 1'b1;
        bus1.rd_sel = {2'(k + 3), 2'(k + 2), 2'(k + 1), 2'(k)};
      end
    end

    // eol: both PUs enabled, repeat done ignored, re-arm via eoc
    bus1.pu_en = 2'b11;
    bus1.eoc   = 1'b1;
    tick();
    idle();
    for (int c = 0; c <= 34; c++) begin
      chk("eol_a", 64'(bus1.eol), 64'(c == 10 || c == 30));
      bus1.pu_done = (c == 5)  ? 2'b01 :
                     (c == 9)  ? 2'b10 :
                     (c == 20) ? 2'b10 :
                     (c == 27) ? 2'b01 :
                     (c == 29) ? 2'b10 : 2'b00;
      bus1.eoc = (c == 25);
      tick();
    end
    idle();

    // eol: eoc beats a same-cycle pu_done
    for (int c = 0; c <= 14; c++) begin
      chk("eol_b", 64'(bus1.eol), 64'(c == 11));
      bus1.pu_done = (c == 3)  ? 2'b01 :
                     (c == 6)  ? 2'b10 :
                     (c == 8)  ? 2'b01 :
                     (c == 10) ? 2'b10 : 2'b00;
      bus1.eoc = (c == 0 || c == 6);
      tick();
    end
    idle();

    // eol: single PU, empty mask, mask change completing the set, masked done
    for (int c = 0; c <= 25; c++) begin
      chk("eol_c", 64'(bus1.eol), 64'(c == 6 || c == 15 || c == 22));
      if (c == 0)  bus1.pu_en = 2'b01;
      if (c == 8)  bus1.pu_en = 2'b00;
      if (c == 14) bus1.pu_en = 2'b11;
      if (c == 17) bus1.pu_en = 2'b01;
      bus1.pu_done = (c == 5)  ? 2'b01 :
                     (c == 10) ? 2'b11 :
                     (c == 12) ? 2'b11 :
                     (c == 19) ? 2'b10 :
                     (c == 21) ? 2'b01 : 2'b00;
      bus1.eoc = (c == 0 || c == 8 || c == 17);
      tick();
    end
    idle();

    // reset drops in-flight reads
    bus1.rd_v = 1'b1; bus1.rd_sel = 8'hE4;
    tick();
    bus1.rd_v = 1'b1; bus1.rd_sel = 8'h1B;
    tick();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int c = 3; c <= 9; c++) begin
      chk("rstf_out_v", 64'(bus1.out_v), 64'(c == 8));
      if (c == 3) begin
        chk("rstf_busy", 64'(bus1.busy), 64'(1'b0));
        chk("rstf_data", bus1.out_data, 64'h0);
      end
      if (c == 8) chk("rstf_new_data", bus1.out_data, 64'h0103_0102_0101_0100);
      idle();
      if (c == 4) begin
        bus1.rd_v = 1'b1; bus1.rd_sel = 8'h00;
      end
      tick();
    end

    // randomized traffic checked by the model
    for (int n = 0; n < 600; n++) begin
      bus1.rd_v   = ($urandom_range(0, 2) != 0);
      bus1.rd_sel = 8'($urandom);
      for (int k = 0; k < 16; k++) bus1.pe_data[k*16 +: 16] = 16'($urandom);
      bus1.pu_done = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      bus1.eoc     = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) bus1.pu_en = 2'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    idle();
    set_pe_fixed();
    repeat (8) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
